// File: rtl/sipo_frame_receiver.sv
// Serial-to-parallel frame receiver: start(0) + N LSB-first data bits + stop(1),
// one-entry valid/ready output buffer, single-cycle frame_err/overrun pulses.
module sipo_frame_receiver #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         serial_in,
  input  logic         bit_en,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // Handshake first so a word loading on the same edge overrides the clear.
    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (!serial_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {serial_in, shift_q[N-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_d = STOP;
          end
        end
        STOP: begin
          state_d = IDLE;
          if (serial_in) begin
            if (!valid_q || data_ready) begin
              dout_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed + randomized bench for sipo_frame_receiver against a frame-level
// model of the output buffer (held word, valid flag, expected pulses).
module tb_sipo_frame_receiver;

  localparam int N = 4;

  logic         clk;
  logic         reset_n;
  logic         serial_in;
  logic         bit_en;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         data_ready;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N-1:0] m_data;
  bit           m_valid;
  bit           e_ovr;
  bit           e_ferr;

  sipo_frame_receiver #(.N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .serial_in  (serial_in),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; stop_edge marks the edge that samples a stop bit.
  task automatic step(input bit stop_edge, input bit stopb, input logic [N-1:0] word,
                      input bit exp_busy);
    bit ld, ov, fe;
    ld = 0; ov = 0; fe = 0;
    if (stop_edge) begin
      if (stopb) begin
        if (!m_valid || data_ready) ld = 1;
        else ov = 1;
      end else begin
        fe = 1;
      end
    end
    @(posedge clk);
    #1;
    if (ld) begin
      m_data  = word;
      m_valid = 1;
    end else if (m_valid && data_ready) begin
      m_valid = 0;
    end
    e_ovr  = ov;
    e_ferr = fe;
    chk("data_valid", 32'(data_valid), 32'(m_valid));
    chk("data_out",   32'(data_out),   32'(m_data));
    chk("frame_err",  32'(frame_err),  32'(e_ferr));
    chk("overrun",    32'(overrun),    32'(e_ovr));
    chk("busy",       32'(busy),       32'(exp_busy));
  endtask

  task automatic send_frame(input logic [N-1:0] word, input bit stopb, input int gap,
                            input bit force_rdy);
    bit b;
    for (int i = 0; i <= N + 1; i++) begin
      if (i == 0)          b = 1'b0;
      else if (i == N + 1) b = stopb;
      else                 b = word[i-1];
      serial_in = b;
      bit_en    = 1'b1;
      if (force_rdy && i == N + 1) data_ready = 1'b1;
      step(i == N + 1, stopb, word, i != N + 1);
      bit_en = 1'b0;
      if (force_rdy && i == N + 1) data_ready = 1'b0;
      for (int g = 0; g < gap; g++) begin
        serial_in = 1'($urandom);
        step(0, 0, '0, i != N + 1);
      end
    end
  endtask

  task automatic idle_steps(input int n);
    serial_in = 1'b1;
    bit_en    = 1'b1;
    for (int k = 0; k < n; k++) step(0, 0, '0, 0);
    bit_en = 1'b0;
  endtask

  initial begin
    logic [N-1:0] w;
    bit           sb;

    reset_n    = 1'b0;
    serial_in  = 1'b1;
    bit_en     = 1'b0;
    data_ready = 1'b0;
    m_data     = '0;
    m_valid    = 0;
    e_ovr      = 0;
    e_ferr     = 0;

    #1;
    chk("rst_data_out",  32'(data_out),   32'h0);
    chk("rst_valid",     32'(data_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err),  32'h0);
    chk("rst_overrun",   32'(overrun),    32'h0);
    chk("rst_busy",      32'(busy),       32'h0);
    #5;
    reset_n = 1'b1;
    step(0, 0, '0, 0);

    // 1: line bits 0,1,1,0,1,1 with data_ready=1
    data_ready = 1'b1;
    send_frame(4'hB, 1, 0, 0);
    chk("t1_data",  32'(data_out),   32'hB);
    chk("t1_valid", 32'(data_valid), 32'h1);
    step(0, 0, '0, 0);
    chk("t1_valid_drop", 32'(data_valid), 32'h0);

    // 2: back-to-back words with consumer stalled
    data_ready = 1'b0;
    send_frame(4'hB, 1, 0, 0);
    send_frame(4'h5, 1, 0, 0);
    chk("t2_overrun", 32'(overrun),  32'h1);
    chk("t2_data",    32'(data_out), 32'hB);
    step(0, 0, '0, 0);
    chk("t2_overrun_pulse", 32'(overrun), 32'h0);
    data_ready = 1'b1;
    step(0, 0, '0, 0);
    chk("t2_drained", 32'(data_valid), 32'h0);
    data_ready = 1'b0;

    // 3: bad stop bit, then a good frame
    send_frame(4'h3, 0, 0, 0);
    chk("t3_ferr",  32'(frame_err),  32'h1);
    chk("t3_valid", 32'(data_valid), 32'h0);
    chk("t3_busy",  32'(busy),       32'h0);
    step(0, 0, '0, 0);
    send_frame(4'hA, 1, 0, 0);
    chk("t3_data", 32'(data_out), 32'hA);
    data_ready = 1'b1;
    step(0, 0, '0, 0);

    // 4: strobe every third cycle, line noise between strobes
    send_frame(4'h6, 1, 2, 0);
    chk("t4_data", 32'(data_out), 32'h6);
    step(0, 0, '0, 0);

    // 5: consume pending word on the same edge a new one completes
    data_ready = 1'b0;
    send_frame(4'h9, 1, 0, 0);
    send_frame(4'hC, 1, 1, 1);
    chk("t5_data",    32'(data_out),   32'hC);
    chk("t5_valid",   32'(data_valid), 32'h1);
    chk("t5_overrun", 32'(overrun),    32'h0);

    // 6: reset after two data bits
    serial_in = 1'b0; bit_en = 1'b1; step(0, 0, '0, 1);
    serial_in = 1'b1;                 step(0, 0, '0, 1);
    serial_in = 1'b0;                 step(0, 0, '0, 1);
    bit_en = 1'b0;
    #2;
    reset_n = 1'b0;
    m_data  = '0;
    m_valid = 0;
    #1;
    chk("t6_rst_data",  32'(data_out),   32'h0);
    chk("t6_rst_valid", 32'(data_valid), 32'h0);
    chk("t6_rst_ferr",  32'(frame_err),  32'h0);
    chk("t6_rst_ovr",   32'(overrun),    32'h0);
    chk("t6_rst_busy",  32'(busy),       32'h0);
    serial_in = 1'b1;
    bit_en    = 1'b1;
    step(0, 0, '0, 0);
    reset_n = 1'b1;
    bit_en  = 1'b0;
    step(0, 0, '0, 0);
    send_frame(4'hF, 1, 0, 0);
    chk("t6_data", 32'(data_out), 32'hF);

    // Randomized frames, gaps, stop errors and consumer stalls
    for (int r = 0; r < 40; r++) begin
      w          = N'($urandom);
      sb         = ($urandom_range(0, 5) != 0);
      data_ready = 1'($urandom);
      send_frame(w, sb, $urandom_range(0, 2), 0);
      if ($urandom_range(0, 2) == 0) idle_steps($urandom_range(1, 3));
    end
    data_ready = 1'b1;
    step(0, 0, '0, 0);
    chk("final_drained", 32'(data_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
